core_alu_issue: RTL and testbench



---
 rtl/letc_pkg.sv | 47 ++++
 rtl/core_alu_issue_if.sv | 41 ++++
 rtl/core_alu_opdec.sv | 45 ++++
 rtl/core_alu_issue.sv | 109 ++++++++++
 tb/tb_core_alu_issue.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/letc_pkg.sv
// Shared integer-pipeline types: ALU opcode/kind enums and stage payloads.
package letc_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_idx_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    KIND_R     = 3'd0,
    KIND_I     = 3'd1,
    KIND_LUI   = 3'd2,
    KIND_AUIPC = 3'd3,
    KIND_LINK  = 3'd4
  } alu_kind_e;

  localparam word_t ALU_LINK_OFFSET = 32'd4;

  typedef struct packed {
    word_t    op1;
    word_t    op2;
    alu_op_e  opcode;
    reg_idx_t rd;
    logic     illegal;
  } issue_t;

  typedef struct packed {
    word_t    result;
    reg_idx_t rd;
    logic     illegal;
  } result_t;

endpackage

// File: rtl/core_alu_issue_if.sv
// Instruction-in, ALU-drive and result-out signals of the ALU issue stage.
interface core_alu_issue_if;
  import letc_pkg::*;

  logic      in_valid;
  logic      in_ready;
  alu_kind_e in_kind;
  logic [2:0] in_funct3;
  logic      in_funct7_5;
  word_t     in_pc;
  word_t     in_rs1_data;
  word_t     in_rs2_data;
  word_t     in_imm;
  reg_idx_t  in_rd;

  word_t     alu_op1;
  word_t     alu_op2;
  alu_op_e   alu_opcode;
  word_t     alu_result;

  logic      out_valid;
  logic      out_ready;
  word_t     out_result;
  reg_idx_t  out_rd;
  logic      out_illegal;

  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7_5, in_pc,
           in_rs1_data, in_rs2_data, in_imm, in_rd, alu_result, out_ready,
    output in_ready, alu_op1, alu_op2, alu_opcode,
           out_valid, out_result, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_kind, in_funct3, in_funct7_5, in_pc,
           in_rs1_data, in_rs2_data, in_imm, in_rd, alu_result, out_ready,
    input  in_ready, alu_op1, alu_op2, alu_opcode,
           out_valid, out_result, out_rd, out_illegal
  );

endinterface

// File: rtl/core_alu_opdec.sv
// Combinational decode of kind/funct3/funct7_5 into ALU opcode and illegal flag.
module core_alu_opdec
  import letc_pkg::*;
(
  input  alu_kind_e  kind,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    opcode_c,
  output logic       illegal_c
);

  logic    is_r;
  logic    is_i;
  alu_op_e base_op;

  always_comb begin
    is_r      = (kind == KIND_R);
    is_i      = (kind == KIND_I);
    base_op   = ALU_ADD;
    opcode_c  = ALU_ADD;
    illegal_c = 1'b0;

    case (funct3)
      3'b000: base_op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: base_op = ALU_SLL;
      3'b010: base_op = ALU_SLT;
      3'b011: base_op = ALU_SLTU;
      3'b100: base_op = ALU_XOR;
      3'b101: base_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: base_op = ALU_OR;
      3'b111: base_op = ALU_AND;
      default: base_op = ALU_ADD;
    endcase

    // bit 30 is only an opcode bit for R-type and for the I-type shift encodings
    illegal_c = funct7_5 &&
                ((is_r && (funct3 != 3'b000) && (funct3 != 3'b101)) ||
                 (is_i && (funct3 == 3'b001)));

    if ((is_r || is_i) && !illegal_c) begin
      opcode_c = base_op;
    end
  end

endmodule

// File: rtl/core_alu_issue.sv
// Two-stage elastic issue/capture around the combinational ALU: S1 drives the ALU, S2 holds the result.
module core_alu_issue
  import letc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  core_alu_issue_if.slave   bus
);

  logic    s1_valid_q, s1_valid_d;
  logic    s2_valid_q, s2_valid_d;
  issue_t  s1_q, s1_d;
  result_t s2_q, s2_d;

  logic    s2_can_load_c;
  logic    s2_load_c;
  logic    s1_load_c;
  logic    in_ready_c;

  alu_op_e dec_opcode_c;
  logic    dec_illegal_c;
  word_t   sel_op1_c;
  word_t   sel_op2_c;

  core_alu_opdec u_opdec (
    .kind      (bus.in_kind),
    .funct3    (bus.in_funct3),
    .funct7_5  (bus.in_funct7_5),
    .opcode_c  (dec_opcode_c),
    .illegal_c (dec_illegal_c)
  );

  // operand selection by instruction kind
  always_comb begin
    sel_op1_c = '0;
    sel_op2_c = '0;
    case (bus.in_kind)
      KIND_R:     begin sel_op1_c = bus.in_rs1_data; sel_op2_c = bus.in_rs2_data;   end
      KIND_I:     begin sel_op1_c = bus.in_rs1_data; sel_op2_c = bus.in_imm;        end
      KIND_LUI:   begin sel_op1_c = '0;              sel_op2_c = bus.in_imm;        end
      KIND_AUIPC: begin sel_op1_c = bus.in_pc;       sel_op2_c = bus.in_imm;        end
      KIND_LINK:  begin sel_op1_c = bus.in_pc;       sel_op2_c = ALU_LINK_OFFSET;   end
      default:    begin sel_op1_c = '0;              sel_op2_c = '0;                end
    endcase
  end

  // handshake and next-state; flush drops both stages and blocks acceptance
  always_comb begin
    s2_can_load_c = !s2_valid_q || bus.out_ready;
    s2_load_c     = s1_valid_q && s2_can_load_c && !flush;
    in_ready_c    = !flush && (!s1_valid_q || s2_can_load_c);
    s1_load_c     = bus.in_valid && in_ready_c;

    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s1_d       = s1_q;
    s2_d       = s2_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_load_c)      s1_valid_d = 1'b1;
      else if (s2_load_c) s1_valid_d = 1'b0;

      if (s2_load_c)          s2_valid_d = 1'b1;
      else if (bus.out_ready) s2_valid_d = 1'b0;
    end

    if (s1_load_c) begin
      s1_d.op1     = sel_op1_c;
      s1_d.op2     = sel_op2_c;
      s1_d.opcode  = dec_opcode_c;
      s1_d.rd      = bus.in_rd;
      s1_d.illegal = dec_illegal_c;
    end

    if (s2_load_c) begin
      s2_d.result  = bus.alu_result;
      s2_d.rd      = s1_q.rd;
      s2_d.illegal = s1_q.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.alu_op1     = s1_q.op1;
  assign bus.alu_op2     = s1_q.op2;
  assign bus.alu_opcode  = s1_q.opcode;
  assign bus.out_valid   = s2_valid_q;
  assign bus.out_result  = s2_q.result;
  assign bus.out_rd      = s2_q.rd;
  assign bus.out_illegal = s2_q.illegal;

endmodule

// File: tb/tb_core_alu_issue.sv
// Directed bench for core_alu_issue with a behavioural ALU attached to the alu_* port.
module tb_core_alu_issue;
  import letc_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   n_total;
  int   n_bad;

  core_alu_issue_if bus ();

  core_alu_issue dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t alu_model(input logic [3:0] op, input word_t a, input word_t b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return 32'($signed(a) < $signed(b));
      4'd4:    return 32'(a < b);
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return word_t'($signed(a) >>> b[4:0]);
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_opcode, bus.alu_op1, bus.alu_op2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input alu_kind_e k, input logic [2:0] f3, input logic f75, input word_t pc,
                       input word_t rs1, input word_t rs2, input word_t imm, input reg_idx_t rd);
    bus.in_valid    = 1'b1;
    bus.in_kind     = k;
    bus.in_funct3   = f3;
    bus.in_funct7_5 = f75;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    bus.in_imm      = imm;
    bus.in_rd       = rd;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/out_valid"},   32'(bus.out_valid), 32'd0);
    check({tag, "/in_ready"},    32'(bus.in_ready), 32'd1);
    check({tag, "/alu_op1"},     bus.alu_op1, 32'd0);
    check({tag, "/alu_op2"},     bus.alu_op2, 32'd0);
    check({tag, "/alu_opcode"},  32'(bus.alu_opcode), 32'd0);
    check({tag, "/out_result"},  bus.out_result, 32'd0);
    check({tag, "/out_rd"},      32'(bus.out_rd), 32'd0);
    check({tag, "/out_illegal"}, 32'(bus.out_illegal), 32'd0);
  endtask

  // one isolated instruction: ALU drive checked at T+1, result at T+2
  task automatic run_single(input string tag, input alu_kind_e k, input logic [2:0] f3, input logic f75,
                            input word_t pc, input word_t rs1, input word_t rs2, input word_t imm,
                            input reg_idx_t rd, input word_t e1, input word_t e2, input logic [3:0] eopc,
                            input word_t eres, input logic eill);
    @(negedge clk);
    drive(k, f3, f75, pc, rs1, rs2, imm, rd);
    #1 check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "/alu_op1"},    bus.alu_op1, e1);
    check({tag, "/alu_op2"},    bus.alu_op2, e2);
    check({tag, "/alu_opcode"}, 32'(bus.alu_opcode), 32'(eopc));
    check({tag, "/early_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "/out_valid"},   32'(bus.out_valid), 32'd1);
    check({tag, "/out_result"},  bus.out_result, eres);
    check({tag, "/out_rd"},      32'(bus.out_rd), 32'(rd));
    check({tag, "/out_illegal"}, 32'(bus.out_illegal), 32'(eill));
  endtask

  initial begin
    int sent;
    int got;
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    flush   = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(KIND_R, 3'd0, 1'b0, '0, '0, '0, '0, '0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    run_single("sub",   KIND_R,     3'b000, 1'b1, 32'h0,    32'd10,         32'd3, 32'h0,        5'd5,
               32'd10, 32'd3, 4'd1, 32'd7, 1'b0);
    run_single("srai",  KIND_I,     3'b101, 1'b1, 32'h0,    32'h8000_0000,  32'h0, 32'h404,      5'd6,
               32'h8000_0000, 32'h404, 4'd7, 32'hF800_0000, 1'b0);
    run_single("link",  KIND_LINK,  3'b000, 1'b0, 32'h100,  32'h55,         32'h66, 32'h0,       5'd1,
               32'h100, 32'd4, 4'd0, 32'h104, 1'b0);
    run_single("r_ill", KIND_R,     3'b111, 1'b1, 32'h0,    32'd5,          32'd6, 32'h0,        5'd7,
               32'd5, 32'd6, 4'd0, 32'd11, 1'b1);
    run_single("lui",   KIND_LUI,   3'b000, 1'b0, 32'h40,   32'hDEAD,       32'h0, 32'h1234_5000, 5'd8,
               32'h0, 32'h1234_5000, 4'd0, 32'h1234_5000, 1'b0);
    run_single("auipc", KIND_AUIPC, 3'b000, 1'b0, 32'h2000, 32'h77,         32'h0, 32'h10,       5'd9,
               32'h2000, 32'h10, 4'd0, 32'h2010, 1'b0);
    run_single("slli_ill", KIND_I,  3'b001, 1'b1, 32'h0,    32'd1,          32'h0, 32'h402,      5'd10,
               32'd1, 32'h402, 4'd0, 32'h403, 1'b1);
    run_single("srl",   KIND_R,     3'b101, 1'b0, 32'h0,    32'h8000_0000,  32'd4, 32'h0,        5'd11,
               32'h8000_0000, 32'd4, 4'd6, 32'h0800_0000, 1'b0);
    run_single("slt",   KIND_R,     3'b010, 1'b0, 32'h0,    32'hFFFF_FFFF,  32'd1, 32'h0,        5'd12,
               32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1, 1'b0);
    run_single("addi_b30", KIND_I,  3'b000, 1'b1, 32'h0,    32'd5,          32'h0, 32'hFFFF_FC00, 5'd13,
               32'd5, 32'hFFFF_FC00, 4'd0, 32'hFFFF_FC05, 1'b0);

    // eight back-to-back ADDIs with out_ready low in loop cycles 3..5
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 3 && c <= 5);
      if (sent < 8) drive(KIND_I, 3'b000, 1'b0, '0, 32'(sent) * 32'h100, '0, 32'(sent), reg_idx_t'(sent));
      else bus.in_valid = 1'b0;
      #1;
      if (c == 3) check("stall/in_ready_low", 32'(bus.in_ready), 32'd0);
      if (c == 5) check("stall/held_result", bus.out_result, 32'h101);
      if (c == 6) check("stall/in_ready_release", 32'(bus.in_ready), 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        check("stall/result", bus.out_result, 32'h101 * 32'(got));
        check("stall/rd", 32'(bus.out_rd), 32'(got));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    check("stall/count", 32'(got), 32'd8);
    @(negedge clk);
    check("stall/no_dup", 32'(bus.out_valid), 32'd0);

    // flush with both stages occupied
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(KIND_I, 3'b000, 1'b0, '0, 32'h10, '0, 32'h1, 5'd1);
    @(negedge clk);
    drive(KIND_I, 3'b000, 1'b0, '0, 32'h20, '0, 32'h2, 5'd2);
    @(negedge clk);
    check("flush/full", 32'(bus.out_valid), 32'd1);
    flush = 1'b1;
    drive(KIND_I, 3'b000, 1'b0, '0, 32'h30, '0, 32'h3, 5'd3);
    #1 check("flush/in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    check("flush/out_valid", 32'(bus.out_valid), 32'd0);
    drive(KIND_R, 3'b100, 1'b0, '0, 32'hF0F0, 32'h0FF0, '0, 5'd4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("flush/new_not_yet", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("flush/new_valid", 32'(bus.out_valid), 32'd1);
    check("flush/new_result", bus.out_result, 32'hFF00);
    check("flush/new_rd", 32'(bus.out_rd), 32'd4);
    @(negedge clk);
    check("flush/no_ghost", 32'(bus.out_valid), 32'd0);

    // reset with both stages occupied
    bus.out_ready = 1'b0;
    drive(KIND_R, 3'b000, 1'b1, '0, 32'd9, 32'd2, '0, 5'd20);
    @(negedge clk);
    drive(KIND_I, 3'b110, 1'b0, '0, 32'h1, '0, 32'h6, 5'd21);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_mid/full", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    check_reset_values("rst_mid");
    @(negedge clk);
    check("rst_mid/stays_empty", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
